fp_align_add: RTL

- Pre-normalisation stage of the single-precision FP add/sub datapath. It sits directly upstream of the leading-one normaliser.
- Unpacks two IEEE-754 operands, orders them by magnitude and right-aligns the smaller mantissa over several cycles.
- Adds or subtracts the 24-bit mantissas and delivers them to the normaliser as a 24-bit magnitude plus carry-out flag, with sign and exponent.
- Valid/ready handshake on both sides; one operation in flight at a time.

---
 rtl/fp_align_add_if.sv | 44 ++++
 rtl/fp_align_add.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/fp_align_add_if.sv
// Purpose: operand/result handshake bundle for the FP add/sub pre-normalisation stage.
// Latency: n/a (wiring only).
// Backpressure: in_valid/in_ready on the operand side, out_valid/out_ready on the result side.
//
// Ports (signals):
//   in_valid, in_ready, a, b, op         operand side
//   out_valid, out_ready, sum, of, sign,
//   exp, special [, grs]                 result side (grs only with FP_ALIGN_STICKY_EN)
// Optional macro: FP_ALIGN_STICKY_EN adds the grs[2:0] result field.
interface fp_align_add_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a;
   logic [31:0] b;
   logic        op;
   logic        out_valid;
   logic        out_ready;
   logic [23:0] sum;
   logic        of;
   logic        sign;
   logic [7:0]  exp;
   logic        special;
`ifdef FP_ALIGN_STICKY_EN
   logic [2:0]  grs;

   modport master (
      output in_valid, a, b, op, out_ready,
      input  in_ready, out_valid, sum, of, sign, exp, special, grs
   );
   modport slave (
      input  in_valid, a, b, op, out_ready,
      output in_ready, out_valid, sum, of, sign, exp, special, grs
   );
`else
   modport master (
      output in_valid, a, b, op, out_ready,
      input  in_ready, out_valid, sum, of, sign, exp, special
   );
   modport slave (
      input  in_valid, a, b, op, out_ready,
      output in_ready, out_valid, sum, of, sign, exp, special
   );
`endif
endinterface

// File: rtl/fp_align_add.sv
// Purpose: single-precision add/sub pre-normalisation: unpack, order by magnitude, align, add/sub mantissas.
// Latency: 1 + ceil(d/SHIFT_STEP) cycles from accept edge to out_valid (d = exponent difference, clamped to 24).
// Backpressure: one operation in flight; result held stable in HOLD until out_ready, in_ready only in IDLE.
//
// Ports:
//   clk      clock, all state changes on rising edge
//   reset_n  synchronous active-low reset
//   bus      fp_align_add_if.slave: operands a/b/op with in_valid/in_ready,
//            result sum/of/sign/exp/special with out_valid/out_ready
// Optional macro: FP_ALIGN_STICKY_EN extends mantissas with guard/round/sticky and drives bus.grs.
module fp_align_add #(
   parameter int SHIFT_STEP = 4
) (
   input  logic       clk,
   input  logic       reset_n,
   fp_align_add_if.slave bus
);

`ifdef FP_ALIGN_STICKY_EN
   localparam int XB = 3;
`else
   localparam int XB = 0;
`endif
   localparam int MW = 24 + XB;
   localparam logic [4:0] STEP = 5'(SHIFT_STEP);

   typedef enum logic [1:0] {IDLE, ALIGN, ADD, HOLD} state_t;

   state_t          state;
   logic            in_ready_r;
   logic            out_valid_r;
   logic [23:0]     sum_r;
   logic            of_r;
   logic            sign_r;
   logic [7:0]      exp_r;
   logic            special_r;
`ifdef FP_ALIGN_STICKY_EN
   logic [2:0]      grs_r;
`endif

   // Operation context captured on the accept edge
   logic [MW-1:0]   big_man;
   logic [MW-1:0]   sml_man;
   logic [7:0]      big_exp;
   logic            big_s;
   logic            sml_s;
   logic            spec_op;
   logic [4:0]      rem;

   // Operand unpack and ordering
   logic [7:0]      a_exp, b_exp;
   logic [22:0]     a_frac, b_frac;
   logic            a_s, b_s;
   logic [23:0]     a_man, b_man;
   logic            a_big;
   logic [7:0]      d_raw;
   logic [4:0]      d_clamp;
   logic            spec_in;

   always_comb begin
      a_exp   = bus.a[30:23];
      b_exp   = bus.b[30:23];
      a_frac  = bus.a[22:0];
      b_frac  = bus.b[22:0];
      a_s     = bus.a[31];
      b_s     = bus.b[31] ^ bus.op;
      // Denormals flush to zero
      a_man   = (a_exp != 8'd0) ? {1'b1, a_frac} : 24'h0;
      b_man   = (b_exp != 8'd0) ? {1'b1, b_frac} : 24'h0;
      // Ties resolve to A so equal magnitudes subtract as A - B
      a_big   = {a_exp, a_frac} >= {b_exp, b_frac};
      d_raw   = a_big ? (a_exp - b_exp) : (b_exp - a_exp);
      d_clamp = (d_raw > 8'd24) ? 5'd24 : d_raw[4:0];
      spec_in = (a_exp == 8'hFF) || (b_exp == 8'hFF);
   end

   // One alignment step
   logic [4:0]      shamt;
   logic [MW-1:0]   sml_shift;
`ifdef FP_ALIGN_STICKY_EN
   logic [MW-1:0]   lost;
`endif

   always_comb begin
      shamt     = (rem > STEP) ? STEP : rem;
      sml_shift = sml_man >> shamt;
`ifdef FP_ALIGN_STICKY_EN
      // Bit 0 is the sticky position; it absorbs everything pushed below it,
      // including its own previous value, so the OR accumulates across steps.
      lost         = sml_man & ~({MW{1'b1}} << shamt);
      sml_shift[0] = sml_shift[0] | (|lost);
`endif
   end

   // Mantissa add/sub; big >= small after alignment so the difference is never negative
   logic [MW:0]     res;
   logic            sub_zero;

   always_comb begin
      if (big_s == sml_s) begin
         res = {1'b0, big_man} + {1'b0, sml_man};
      end else begin
         res = {1'b0, big_man - sml_man};
      end
      sub_zero = (big_s != sml_s) && (res == '0);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state       <= IDLE;
         in_ready_r  <= 1'b0;
         out_valid_r <= 1'b0;
         sum_r       <= 24'h0;
         of_r        <= 1'b0;
         sign_r      <= 1'b0;
         exp_r       <= 8'h0;
         special_r   <= 1'b0;
`ifdef FP_ALIGN_STICKY_EN
         grs_r       <= 3'b000;
`endif
         big_man     <= '0;
         sml_man     <= '0;
         big_exp     <= 8'h0;
         big_s       <= 1'b0;
         sml_s       <= 1'b0;
         spec_op     <= 1'b0;
         rem         <= 5'd0;
      end else begin
         case (state)
            IDLE: begin
               in_ready_r <= 1'b1;
               if (in_ready_r && bus.in_valid) begin
                  in_ready_r <= 1'b0;
                  big_man    <= a_big ? (MW'(a_man) << XB) : (MW'(b_man) << XB);
                  sml_man    <= a_big ? (MW'(b_man) << XB) : (MW'(a_man) << XB);
                  big_exp    <= a_big ? a_exp : b_exp;
                  big_s      <= a_big ? a_s : b_s;
                  sml_s      <= a_big ? b_s : a_s;
                  spec_op    <= spec_in;
                  rem        <= d_clamp;
                  state      <= (d_clamp == 5'd0 || spec_in) ? ADD : ALIGN;
               end
            end
            ALIGN: begin
               sml_man <= sml_shift;
               rem     <= rem - shamt;
               if (rem <= STEP) begin
                  state <= ADD;
               end
            end
            ADD: begin
               sum_r       <= res[MW-1 -: 24];
               of_r        <= res[MW];
               sign_r      <= sub_zero ? 1'b0 : big_s;
               exp_r       <= big_exp;
               special_r   <= spec_op;
`ifdef FP_ALIGN_STICKY_EN
               grs_r       <= res[2:0];
`endif
               out_valid_r <= 1'b1;
               state       <= HOLD;
            end
            HOLD: begin
               if (bus.out_ready) begin
                  out_valid_r <= 1'b0;
                  in_ready_r  <= 1'b1;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.in_ready  = in_ready_r;
   assign bus.out_valid = out_valid_r;
   assign bus.sum       = sum_r;
   assign bus.of        = of_r;
   assign bus.sign      = sign_r;
   assign bus.exp       = exp_r;
   assign bus.special   = special_r;
`ifdef FP_ALIGN_STICKY_EN
   assign bus.grs       = grs_r;
`endif

endmodule
